inst_encoder: RTL and testbench

Sequential RV32I instruction encoder and program loader: the write-side counterpart of the control unit's instruction decoder. It accepts field-level instruction requests over a valid/ready handshake, assembles them into 32-bit words using the same opcode classes the CPU decodes, and writes them sequentially into instruction memory. It is used for boot loading and self-test program generation ahead of the pipeline.

---
 rtl/inst_encoder_if.sv | 29 ++
 rtl/inst_encoder.sv | 195 +++++++++++++++++++
 tb/tb_inst_encoder.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// inst_encoder_if: field-level instruction request channel.
//   valid  request present (master -> slave)
//   ready  slave can accept the request (slave -> master)
//   fmt    format: 0 R, 1 I-ALU, 2 LW, 3 JALR, 4 S, 5 B, 6 U, 7 J
//   funct3 funct3 for R, I-ALU, S and B
//   alt    inst[30] select for SUB, SRA and SRAI
//   rd, rs1, rs2  register fields
//   imm    byte-offset immediate, or the full upper value for U
interface inst_encoder_if;
  logic        valid;
  logic        ready;
  logic [2:0]  fmt;
  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  modport master (
    output valid, fmt, funct3, alt, rd, rs1, rs2, imm,
    input  ready
  );

  modport slave (
    input  valid, fmt, funct3, alt, rd, rs1, rs2, imm,
    output ready
  );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: sequential RV32I instruction encoder and program loader.
// Accepts field-level requests, encodes them into 32-bit instruction words and
// writes them to consecutive instruction memory addresses.
//   clk, rst_n   clock and synchronous active-low reset
//   start        reload pointer from base_addr, clear count/err/full
//   base_addr    first word address after start
//   req          request channel (inst_encoder_if.slave)
//   mem_we       one-cycle write strobe; mem_addr/mem_wdata hold otherwise
//   inst_count   words written since last start or reset
//   full         inst_count == MAX_WORDS
//   err          sticky: at least one request was illegal
//
// state | meaning
// ------+---------------------------------------------------------
// READY | idle, req.ready asserted unless full or start
// ENC   | latched request is encoded and checked for legality
// WR    | mem_we high with registered address and word
module inst_encoder #(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  inst_encoder_if.slave     req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   inst_count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {READY, ENC, WR} state_t;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_LW   = 3'd2;
  localparam logic [2:0] FMT_JALR = 3'd3;
  localparam logic [2:0] FMT_S    = 3'd4;
  localparam logic [2:0] FMT_B    = 3'd5;
  localparam logic [2:0] FMT_U    = 3'd6;
  localparam logic [2:0] FMT_J    = 3'd7;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_J    = 7'b1101111;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              we_q;

  logic [2:0]        fmt_q;
  logic [2:0]        f3_q;
  logic              alt_q;
  logic [4:0]        rd_q;
  logic [4:0]        rs1_q;
  logic [4:0]        rs2_q;
  logic [31:0]       imm_q;

  logic [31:0]       word;
  logic              legal;
  logic [6:0]        funct7;
  logic              fits12;
  logic              fits13;
  logic              fits21;

  assign req.ready = (state == READY) & ~full & ~start & rst_n;

  // start aborts a write already in its WR cycle, so the strobe is gated here
  assign mem_we = we_q & ~start;

  assign funct7 = alt_q ? 7'b0100000 : 7'b0000000;
  // signed range checks: the upper bits must be a pure sign extension
  assign fits12 = (&imm_q[31:11]) | ~(|imm_q[31:11]);
  assign fits13 = (&imm_q[31:12]) | ~(|imm_q[31:12]);
  assign fits21 = (&imm_q[31:20]) | ~(|imm_q[31:20]);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt_q)
      FMT_R: begin
        word  = {funct7, rs2_q, rs1_q, f3_q, rd_q, OP_R};
        legal = 1'b1;
      end
      FMT_I: begin
        if (f3_q == 3'b001 || f3_q == 3'b101) begin
          word  = {funct7, imm_q[4:0], rs1_q, f3_q, rd_q, OP_I};
          legal = ~(|imm_q[31:5]);
        end else begin
          word  = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_I};
          legal = fits12;
        end
      end
      FMT_LW: begin
        word  = {imm_q[11:0], rs1_q, 3'b010, rd_q, OP_LW};
        legal = fits12;
      end
      FMT_JALR: begin
        word  = {imm_q[11:0], rs1_q, 3'b000, rd_q, OP_JALR};
        legal = fits12;
      end
      FMT_S: begin
        word  = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OP_S};
        legal = fits12 & ~f3_q[2] & (f3_q != 3'b011);
      end
      FMT_B: begin
        word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1],
                 imm_q[11], OP_B};
        legal = fits13 & ~imm_q[0] & (f3_q != 3'b010) & (f3_q != 3'b011);
      end
      FMT_U: begin
        word  = {imm_q[31:12], rd_q, OP_U};
        legal = ~(|imm_q[11:0]);
      end
      FMT_J: begin
        word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OP_J};
        legal = fits21 & ~imm_q[0];
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= READY;
      ptr        <= '0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
      fmt_q      <= '0;
      f3_q       <= '0;
      alt_q      <= 1'b0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
    end else if (start) begin
      state      <= READY;
      ptr        <= base_addr;
      we_q       <= 1'b0;
      inst_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        READY: begin
          if (req.valid && req.ready) begin
            fmt_q <= req.fmt;
            f3_q  <= req.funct3;
            alt_q <= req.alt;
            rd_q  <= req.rd;
            rs1_q <= req.rs1;
            rs2_q <= req.rs2;
            imm_q <= req.imm;
            state <= ENC;
          end
        end
        ENC: begin
          if (legal) begin
            mem_addr  <= ptr;
            mem_wdata <= word;
            we_q      <= 1'b1;
            state     <= WR;
          end else begin
            err   <= 1'b1;
            state <= READY;
          end
        end
        WR: begin
          we_q       <= 1'b0;
          ptr        <= ptr + ADDR_W'(1);
          inst_count <= inst_count + (ADDR_W+1)'(1);
          full       <= (inst_count == (ADDR_W+1)'(MAX_WORDS - 1));
          state      <= READY;
        end
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;

  typedef struct {
    logic [2:0]  fmt;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    bit          legal;
    logic [31:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [12:0] inst_count;
  logic        full;
  logic        err;

  logic        s_start;
  logic [1:0]  s_base;
  logic        s_we;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;
  logic        s_full;
  logic        s_err;

  int vectors    = 0;
  int miscompares = 0;

  logic [11:0] exp_ptr;
  logic [12:0] exp_cnt;
  bit          exp_err;

  inst_encoder_if m_if ();
  inst_encoder_if s_if ();

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .req(m_if.slave), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .inst_count(inst_count), .full(full), .err(err)
  );

  inst_encoder #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .base_addr(s_base),
    .req(s_if.slave), .mem_we(s_we), .mem_addr(s_addr),
    .mem_wdata(s_wdata), .inst_count(s_count), .full(s_full), .err(s_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] fmt, input logic [2:0] f3, input logic alt,
                              input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input bit legal, input logic [31:0] word);
    vec_t v;
    v.fmt = fmt; v.f3 = f3; v.alt = alt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.legal = legal; v.word = word;
    return v;
  endfunction

  // Reference encoder: legality from signed ranges, word from shifted fields.
  function automatic vec_t model(input vec_t r);
    vec_t v = r;
    int   s = $signed(r.imm);
    logic [31:0] u = r.imm;
    logic [31:0] rd  = 32'(r.rd)  << 7;
    logic [31:0] rs1 = 32'(r.rs1) << 15;
    logic [31:0] rs2 = 32'(r.rs2) << 20;
    logic [31:0] f3  = 32'(r.f3)  << 12;
    logic [31:0] a30 = r.alt ? 32'h4000_0000 : 32'h0;
    case (r.fmt)
      3'd0: begin v.legal = 1; v.word = a30 | rs2 | rs1 | f3 | rd | 32'h33; end
      3'd1: begin
        if (r.f3 == 3'd1 || r.f3 == 3'd5) begin
          v.legal = (u < 32);
          v.word  = a30 | ((u & 32'h1f) << 20) | rs1 | f3 | rd | 32'h13;
        end else begin
          v.legal = (s >= -2048 && s <= 2047);
          v.word  = ((u & 32'hfff) << 20) | rs1 | f3 | rd | 32'h13;
        end
      end
      3'd2: begin
        v.legal = (s >= -2048 && s <= 2047);
        v.word  = ((u & 32'hfff) << 20) | rs1 | (32'd2 << 12) | rd | 32'h03;
      end
      3'd3: begin
        v.legal = (s >= -2048 && s <= 2047);
        v.word  = ((u & 32'hfff) << 20) | rs1 | rd | 32'h67;
      end
      3'd4: begin
        v.legal = (s >= -2048 && s <= 2047) && (r.f3 <= 3'd2);
        v.word  = (((u >> 5) & 32'h7f) << 25) | rs2 | rs1 | f3 | ((u & 32'h1f) << 7) | 32'h23;
      end
      3'd5: begin
        v.legal = (s >= -4096 && s <= 4095) && (s % 2 == 0) && r.f3 != 3'd2 && r.f3 != 3'd3;
        v.word  = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | rs2 | rs1 | f3 |
                  (((u >> 1) & 32'hf) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      end
      3'd6: begin
        v.legal = (u % 4096 == 0);
        v.word  = (u & 32'hffff_f000) | rd | 32'h37;
      end
      default: begin
        v.legal = (s >= -1048576 && s <= 1048575) && (s % 2 == 0);
        v.word  = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) |
                  (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12) | rd | 32'h6f;
      end
    endcase
    return v;
  endfunction

  task automatic drive(input vec_t v);
    m_if.fmt = v.fmt; m_if.funct3 = v.f3; m_if.alt = v.alt;
    m_if.rd = v.rd; m_if.rs1 = v.rs1; m_if.rs2 = v.rs2; m_if.imm = v.imm;
    m_if.valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic wait_hs(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (m_if.ready === 1'b1) ok = 1;
      @(posedge clk); #1;
    end
    m_if.valid = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    bit ok;
    drive(v);
    wait_hs(ok);
    chk({nm, " handshake"}, 64'(ok), 64'd1);
    if (!ok) return;
    @(negedge clk);
    chk({nm, " we in ENC"}, 64'(mem_we), 64'd0);
    @(negedge clk);
    chk({nm, " we"}, 64'(mem_we), 64'(v.legal));
    if (v.legal) begin
      chk({nm, " addr"}, 64'(mem_addr), 64'(exp_ptr));
      chk({nm, " wdata"}, 64'(mem_wdata), 64'(v.word));
    end else begin
      exp_err = 1;
    end
    chk({nm, " err"}, 64'(err), 64'(exp_err));
    @(negedge clk);
    if (v.legal) begin
      exp_ptr = exp_ptr + 12'd1;
      exp_cnt = exp_cnt + 13'd1;
    end
    chk({nm, " ready"}, 64'(m_if.ready), 64'd1);
    chk({nm, " count"}, 64'(inst_count), 64'(exp_cnt));
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [11:0] b);
    start = 1'b1; base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
    exp_ptr = b; exp_cnt = 0; exp_err = 0;
  endtask

  vec_t tbl[15];
  int   bnd[10] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, 1048574, 1048576, -1048576};

  initial begin
    vec_t v;
    bit   ok;
    bit   seen;
    logic [1:0] got_a;

    tbl[0]  = mk(3'd0, 3'd0, 1'b0, 5'd3,  5'd1, 5'd2, 32'h0,        1, 32'h002081B3);
    tbl[1]  = mk(3'd0, 3'd0, 1'b1, 5'd5,  5'd6, 5'd7, 32'h0,        1, 32'h407302B3);
    tbl[2]  = mk(3'd6, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h12345000, 1, 32'h12345537);
    tbl[3]  = mk(3'd5, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'hFFFFFFF8, 1, 32'hFE208CE3);
    tbl[4]  = mk(3'd7, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h800,      1, 32'h001000EF);
    tbl[5]  = mk(3'd1, 3'd0, 1'b0, 5'd1,  5'd2, 5'd0, 32'h800,      0, 32'h0);
    tbl[6]  = mk(3'd5, 3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'h3,        0, 32'h0);
    tbl[7]  = mk(3'd0, 3'd0, 1'b0, 5'd3,  5'd1, 5'd2, 32'h0,        1, 32'h002081B3);
    tbl[8]  = mk(3'd1, 3'd0, 1'b0, 5'd1,  5'd2, 5'd0, 32'hFFFFFFFF, 1, 32'hFFF10093);
    tbl[9]  = mk(3'd1, 3'd5, 1'b1, 5'd1,  5'd2, 5'd0, 32'h3,        1, 32'h40315093);
    tbl[10] = mk(3'd4, 3'd2, 1'b0, 5'd0,  5'd1, 5'd2, 32'h4,        1, 32'h0020A223);
    tbl[11] = mk(3'd4, 3'd3, 1'b0, 5'd0,  5'd1, 5'd2, 32'h4,        0, 32'h0);
    tbl[12] = mk(3'd2, 3'd7, 1'b0, 5'd5,  5'd6, 5'd0, 32'hFFFFFFFC, 1, 32'hFFC32283);
    tbl[13] = mk(3'd3, 3'd5, 1'b0, 5'd1,  5'd5, 5'd0, 32'h0,        1, 32'h000280E7);
    tbl[14] = mk(3'd6, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h12345001, 0, 32'h0);

    rst_n = 1'b0; start = 1'b0; base_addr = '0; s_start = 1'b0; s_base = '0;
    m_if.valid = 1'b0; m_if.fmt = '0; m_if.funct3 = '0; m_if.alt = 1'b0;
    m_if.rd = '0; m_if.rs1 = '0; m_if.rs2 = '0; m_if.imm = '0;
    s_if.valid = 1'b0; s_if.fmt = '0; s_if.funct3 = '0; s_if.alt = 1'b0;
    s_if.rd = 5'd3; s_if.rs1 = 5'd1; s_if.rs2 = 5'd2; s_if.imm = '0;
    exp_ptr = 0; exp_cnt = 0; exp_err = 0;

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset mem_we", 64'(mem_we), 0);
    chk("reset mem_addr", 64'(mem_addr), 0);
    chk("reset mem_wdata", 64'(mem_wdata), 0);
    chk("reset count", 64'(inst_count), 0);
    chk("reset full", 64'(full), 0);
    chk("reset err", 64'(err), 0);
    chk("reset ready", 64'(m_if.ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready after reset", 64'(m_if.ready), 1);
    @(posedge clk); #1;

    // start together with valid: request must not be taken
    drive(tbl[0]);
    start = 1'b1; base_addr = 12'h0;
    @(negedge clk);
    chk("ready during start", 64'(m_if.ready), 0);
    @(posedge clk); #1;
    start = 1'b0; m_if.valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("no write after start+valid", 64'(mem_we), 0);
    chk("count after start+valid", 64'(inst_count), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // start during ENC aborts and clears err
    drive(tbl[1]);
    wait_hs(ok);
    chk("abort enc handshake", 64'(ok), 1);
    start = 1'b1; base_addr = 12'h100;
    @(negedge clk);
    chk("abort enc we", 64'(mem_we), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("abort enc we after", 64'(mem_we), 0);
    chk("abort enc err", 64'(err), 0);
    chk("abort enc count", 64'(inst_count), 0);
    @(posedge clk); #1;
    exp_ptr = 12'h100; exp_cnt = 0; exp_err = 0;
    run_vec("after enc abort", tbl[2]);

    // start during WR: strobe suppressed in that cycle
    drive(tbl[0]);
    wait_hs(ok);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'h200;
    @(negedge clk);
    chk("abort wr we", 64'(mem_we), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("abort wr count", 64'(inst_count), 0);
    @(posedge clk); #1;
    exp_ptr = 12'h200; exp_cnt = 0; exp_err = 0;
    run_vec("after wr abort", tbl[3]);

    // randomized requests against the reference model
    do_start(12'($urandom));
    for (int i = 0; i < 150; i++) begin
      v.fmt = 3'($urandom); v.f3 = 3'($urandom); v.alt = 1'($urandom);
      v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
      case ($urandom_range(0, 4))
        0: v.imm = $urandom;
        1: v.imm = 32'(int'($urandom_range(0, 10000)) - 5000);
        2: v.imm = $urandom & 32'hFFFF_F000;
        3: v.imm = 32'($urandom_range(0, 40));
        default: v.imm = 32'(bnd[$urandom_range(0, 9)]);
      endcase
      run_vec($sformatf("rnd%0d", i), model(v));
    end

    // reset during WR
    drive(tbl[0]);
    wait_hs(ok);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst wr mem_we", 64'(mem_we), 0);
    chk("rst wr mem_addr", 64'(mem_addr), 0);
    chk("rst wr mem_wdata", 64'(mem_wdata), 0);
    chk("rst wr count", 64'(inst_count), 0);
    chk("rst wr err", 64'(err), 0);
    chk("rst wr full", 64'(full), 0);
    chk("rst wr ready", 64'(m_if.ready), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst wr ready after", 64'(m_if.ready), 1);
    @(posedge clk); #1;

    // small memory: wrap from base 3 and fill
    s_start = 1'b1; s_base = 2'd3;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_if.valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (s_if.ready === 1'b1) ok = 1;
        @(posedge clk); #1;
      end
      s_if.valid = 1'b0;
      chk($sformatf("small hs%0d", k), 64'(ok), 1);
      seen = 0; got_a = '0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (s_we === 1'b1 && !seen) begin seen = 1; got_a = s_addr; end
      end
      chk($sformatf("small we%0d", k), 64'(seen), 1);
      chk($sformatf("small addr%0d", k), 64'(got_a), 64'((3 + k) % 4));
      @(posedge clk); #1;
    end
    s_if.valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("small full", 64'(s_full), 1);
      chk("small ready when full", 64'(s_if.ready), 0);
      chk("small no we when full", 64'(s_we), 0);
      @(posedge clk); #1;
    end
    chk("small count", 64'(s_count), 4);
    s_if.valid = 1'b0;
    s_start = 1'b1; s_base = 2'd0;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(negedge clk);
    chk("small full cleared", 64'(s_full), 0);
    chk("small ready after start", 64'(s_if.ready), 1);
    chk("small count cleared", 64'(s_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
